// File: rtl/pll_lock_sequencer_if.sv
// PLL lock sequencer status/control bundle: lock input, relock request, resets and counters.
// Latency: none, wires only.
// Backpressure: none; every signal is level or single-cycle pulse, with no handshake.
// Ports (master = sequencer side):
//   pll_locked, relock_req          -> into the sequencer
//   pll_rst, sys_rst, ready,
//   timeout_cnt, loss_cnt           <- out of the sequencer
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
) ();
  logic             pll_locked;
  logic             relock_req;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] loss_cnt;

  modport master (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output timeout_cnt,
    output loss_cnt
  );

  modport slave (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  timeout_cnt,
    input  loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulse pll_rst, wait for lock, require stable lock, then release sys_rst.
// Latency: pll_locked reaches the FSM after 2 sync flops; all outputs are registered (1 cycle).
// Backpressure: none; relock_req is a single-cycle pulse and is always accepted.
// Ports:
//   refclk  - free-running reference clock, sole clock
//   rst     - synchronous active-high reset
//   bus     - master modport: pll_locked/relock_req in; pll_rst/sys_rst/ready/timeout_cnt/loss_cnt out
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_sequencer_if.master  bus
);

  // One shared cycle counter, sized for the largest of the three loads.
  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_V = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0]    C_RST  = CW'(RST_CYCLES);
  localparam logic [CW-1:0]    C_TO   = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0]    C_STAB = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]    C_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] C_SAT  = '1;
  localparam logic [CNT_W-1:0] C_INC  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_PRST = 2'd0,
    S_WAIT = 2'd1,
    S_STAB = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_lk;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_timeout_inc;
  logic             w_loss_inc;

  // Next-state logic. The counter is loaded on state entry and each state
  // leaves on the cycle it sees a count of 1, so a load of N gives N cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_inc = 1'b0;
    w_loss_inc    = 1'b0;
    if (bus.relock_req) begin
      // Overrides any coincident timeout or loss, which then go uncounted.
      w_state_nxt = S_PRST;
      w_cnt_nxt   = C_RST;
    end else begin
      case (r_state)
        S_PRST: begin
          if (r_cnt == C_ONE) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_TO;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
        S_WAIT: begin
          if (r_lk) begin
            w_state_nxt = S_STAB;
            w_cnt_nxt   = C_STAB;
          end else if (r_cnt == C_ONE) begin
            w_state_nxt   = S_PRST;
            w_cnt_nxt     = C_RST;
            w_timeout_inc = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
        S_STAB: begin
          if (!r_lk) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_TO;
          end else if (r_cnt == C_ONE) begin
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
        S_RUN: begin
          if (!r_lk) begin
            w_state_nxt = S_PRST;
            w_cnt_nxt   = C_RST;
            w_loss_inc  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_PRST;
          w_cnt_nxt   = C_RST;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and cannot glitch.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1       <= 1'b0;
      r_lk          <= 1'b0;
      r_state       <= S_PRST;
      r_cnt         <= C_RST;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_timeout_cnt <= '0;
      r_loss_cnt    <= '0;
    end else begin
      r_sync1   <= bus.pll_locked;
      r_lk      <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pll_rst <= (w_state_nxt == S_PRST);
      r_sys_rst <= (w_state_nxt != S_RUN);
      r_ready   <= (w_state_nxt == S_RUN);
      if (w_timeout_inc && (r_timeout_cnt != C_SAT)) begin
        r_timeout_cnt <= r_timeout_cnt + C_INC;
      end
      if (w_loss_inc && (r_loss_cnt != C_SAT)) begin
        r_loss_cnt <= r_loss_cnt + C_INC;
      end
    end
  end

  assign bus.pll_rst     = r_pll_rst;
  assign bus.sys_rst     = r_sys_rst;
  assign bus.ready       = r_ready;
  assign bus.timeout_cnt = r_timeout_cnt;
  assign bus.loss_cnt    = r_loss_cnt;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, meaning the number of cycles pll_rst is held high per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000, meaning the maximum cycles to wait for lock after pll_rst release (min 1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, meaning the consecutive synchronized-locked cycles required before release (min 1).
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of the status counters.
REQ-005 SHALL have port refclk  in  1  free-running reference clock; sole clock of the block.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port pll_locked  in  1  PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port relock_req  in  1  single-cycle request to force a full PLL re-lock.
REQ-009 SHALL have port pll_rst  out  1  reset driven to the PLL.
REQ-010 SHALL have port sys_rst  out  1  synchronous, active-high reset for logic downstream of the PLL output clock.
REQ-011 SHALL have port ready  out  1  high only in state RUN.
REQ-012 SHALL have port timeout_cnt  out  CNT_W  saturating count of lock-timeout events.
REQ-013 SHALL have port loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN.

Function
REQ-014 SHALL synchronize pll_locked through exactly two refclk flops; "lk" below denotes the second flop's output, and all decisions SHALL use lk only.
REQ-015 SHALL implement the states PRST, WAIT, STAB and RUN with one shared down/up cycle counter.
REQ-016 PRST SHALL drive pll_rst=1 and sys_rst=1, and SHALL go to WAIT after exactly RST_CYCLES cycles in PRST.
REQ-017 WAIT SHALL drive pll_rst=0 and sys_rst=1, and SHALL go to STAB on the first cycle with lk=1.
REQ-018 If lk stays 0 for LOCK_TIMEOUT cycles in WAIT, the block SHALL go to PRST and increment timeout_cnt by 1.
REQ-019 STAB SHALL drive pll_rst=0 and sys_rst=1, and SHALL go to RUN after STABLE_CYCLES consecutive cycles with lk=1.
REQ-020 Any lk=0 in STAB SHALL return the block to WAIT with a freshly loaded timeout counter; no counter increments.
REQ-021 RUN SHALL drive pll_rst=0, sys_rst=0 and ready=1.
REQ-022 A cycle with lk=0 in RUN SHALL make sys_rst=1 and ready=0 on the next cycle, move the block to PRST, and increment loss_cnt by 1.
REQ-023 relock_req=1 in any state SHALL force PRST next cycle with a full RST_CYCLES count; relock_req has priority over every other transition.
REQ-024 relock_req SHALL NOT increment either counter, including when it coincides with a timeout or a loss in the same cycle.
REQ-025 timeout_cnt and loss_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 sys_rst, pll_rst and ready SHALL be registered outputs, free of combinational glitches.
REQ-027 sys_rst SHALL deassert exactly one cycle after the STAB->RUN transition is decided, with ready rising on the same edge.
REQ-028 Counter widths SHALL be derived from the parameters using clog2; there SHALL be no truncation at the maximum parameter values.

Reset
REQ-029 On rst=1 the block SHALL enter PRST with the counter loaded to RST_CYCLES, drive pll_rst=1, sys_rst=1 and ready=0, clear timeout_cnt and loss_cnt to 0, and clear both synchronizer flops to 0.
REQ-030 rst asserted in any state, including mid-RUN, SHALL restart the full sequence; rst has priority over relock_req.
REQ-031 After rst deasserts, pll_rst SHALL stay high for RST_CYCLES further cycles.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=8)
REQ-032 Nominal lock: pll_locked rises 5 cycles after pll_rst falls and stays high -> pll_rst high for 4 cycles, then sys_rst falls 2+8+1 cycles after pll_locked rises, ready=1, and both counters remain 0.
REQ-033 Timeout retry: pll_locked held low -> pll_rst re-pulses every 4+20 cycles, timeout_cnt increments once per retry and stops at 255 after 255 retries.
REQ-034 Stabilize glitch: pll_locked drops for 1 cycle at STAB count 5 -> state returns to WAIT, then re-enters STAB, and sys_rst stays high throughout.
REQ-035 Loss in RUN: pll_locked falls -> sys_rst=1 within 3 cycles of the pin edge (2 sync + 1), loss_cnt=1, pll_rst pulses 4 cycles, and the block re-locks.
REQ-036 relock_req in RUN coincident with pll_locked falling -> PRST, loss_cnt unchanged.
REQ-037 rst in STAB -> outputs take their reset values on the next edge and the counters read 0.
